// File: rtl/game_state_pkg.sv
// Shared types and constants for the Tetris game sequencer and board datapath.
package game_state_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_SPAWN = 3'd1,
    SEQ_FALL  = 3'd2,
    SEQ_LOCK  = 3'd3,
    SEQ_SCAN  = 3'd4,
    SEQ_SHIFT = 3'd5,
    SEQ_OVER  = 3'd6
  } seq_state_t;

  // Playfield height shared with the board datapath; row 0 is the top.
  localparam int GAME_ROWS = 20;

  function automatic logic is_playing(input seq_state_t s);
    return (s == SEQ_SPAWN) || (s == SEQ_FALL) || (s == SEQ_LOCK) ||
           (s == SEQ_SCAN)  || (s == SEQ_SHIFT);
  endfunction

endpackage

// File: rtl/game_sequencer_gravity_timer.sv
// Gravity pacing counter: tick fires on the last count of each GRAVITY_DIV-cycle window.
module gravity_timer #(
  parameter int GRAVITY_DIV = 8
) (
  input  logic game_clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(GRAVITY_DIV);
  localparam logic [CW-1:0] LAST = CW'(GRAVITY_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Piece-life phase controller: spawn, gravity, lock, bottom-up line clear.
// Optional soft drop input is enabled by defining GAME_SEQ_SOFT_DROP_EN.
module game_sequencer
  import game_state_pkg::*;
#(
  parameter int ROWS        = GAME_ROWS,
  parameter int GRAVITY_DIV = 8,
  parameter int LINE_CNT_W  = 10
) (
  input  logic                    game_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    spawn_ack,
  input  logic                    spawn_blocked,
  input  logic                    piece_touching,
  input  logic                    row_full,
`ifdef GAME_SEQ_SOFT_DROP_EN
  input  logic                    soft_drop,
`endif
  output logic                    spawn_req,
  output logic                    drop_en,
  output logic                    lock_en,
  output logic                    shift_en,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    playing,
  output logic                    game_over,
  output logic [LINE_CNT_W-1:0]   lines_cleared,
  output seq_state_t              state_dbg
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  seq_state_t            state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [LINE_CNT_W-1:0] lines_q, lines_d;

  logic in_fall;
  logic soft_w;
  logic timer_tick;
  logic grav_tick;

`ifdef GAME_SEQ_SOFT_DROP_EN
  assign soft_w = soft_drop;
`else
  assign soft_w = 1'b0;
`endif

  assign in_fall = (state_q == SEQ_FALL);

  // Holding the counter clear while soft drop is active makes release restart
  // a full gravity window.
  gravity_timer #(
    .GRAVITY_DIV(GRAVITY_DIV)
  ) u_gravity (
    .game_clk(game_clk),
    .reset   (reset),
    .clear   (!in_fall || soft_w),
    .en      (in_fall),
    .tick    (timer_tick)
  );

  assign grav_tick = timer_tick || (in_fall && soft_w);

  // Handshake: spawn_req is held high in SPAWN until the cycle spawn_ack is seen;
  // that same cycle completes the transfer (ack may arrive in the first cycle).
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    lines_d   = lines_q;
    spawn_req = 1'b0;
    drop_en   = 1'b0;
    lock_en   = 1'b0;
    shift_en  = 1'b0;
    game_over = 1'b0;
    playing   = is_playing(state_q);
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d = SEQ_SPAWN;
          lines_d = '0;
        end
      end
      SEQ_SPAWN: begin
        spawn_req = 1'b1;
        if (spawn_ack) begin
          state_d = spawn_blocked ? SEQ_OVER : SEQ_FALL;
        end
      end
      SEQ_FALL: begin
        if (grav_tick) begin
          if (piece_touching) begin
            state_d = SEQ_LOCK;
          end else begin
            drop_en = 1'b1;
          end
        end
      end
      SEQ_LOCK: begin
        lock_en = 1'b1;
        row_d   = ROW_LAST;
        state_d = SEQ_SCAN;
      end
      SEQ_SCAN: begin
        if (row_full) begin
          state_d = SEQ_SHIFT;
        end else if (row_q == '0) begin
          state_d = SEQ_SPAWN;
        end else begin
          row_d = row_q - 1'b1;
        end
      end
      SEQ_SHIFT: begin
        shift_en = 1'b1;
        lines_d  = (&lines_q) ? lines_q : lines_q + 1'b1;
        state_d  = SEQ_SCAN;
      end
      SEQ_OVER: begin
        game_over = 1'b1;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
    // An in-flight operation is abandoned without issuing its pulse.
    if (reset) begin
      spawn_req = 1'b0;
      drop_en   = 1'b0;
      lock_en   = 1'b0;
      shift_en  = 1'b0;
      game_over = 1'b0;
      playing   = 1'b0;
    end
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      row_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      lines_q <= lines_d;
    end
  end

  assign row_idx       = row_q;
  assign lines_cleared = lines_q;
  assign state_dbg     = state_q;

  a_pulse_onehot : assert property (@(posedge game_clk)
    $onehot0({drop_en, lock_en, shift_en}));
  a_spawn_excl : assert property (@(posedge game_clk)
    !(spawn_req && (drop_en || lock_en || shift_en)));

endmodule

// File: tb/tb_game_sequencer.sv
// Table-driven bench for game_sequencer; a second instance with a 2-bit line
// counter exercises saturation on the same stimulus.
module tb_game_sequencer;
  import game_state_pkg::*;

  localparam int ROWS = 20;
  localparam int GDIV = 8;
  localparam int LW   = 10;
  localparam int LW2  = 2;
  localparam int RW   = $clog2(ROWS);
  localparam int W1   = 3 + 4 + RW + 2 + LW;
  localparam int W2   = 3 + 4 + RW + 2 + LW2;

  // ---------------- clock / reset ----------------
  logic game_clk = 1'b0;
  always #5 game_clk = ~game_clk;

  logic reset, start, spawn_ack, spawn_blocked, piece_touching, row_full;
`ifdef GAME_SEQ_SOFT_DROP_EN
  logic soft_drop;
`endif

  logic            a_sreq, a_drop, a_lock, a_shift, a_play, a_over;
  logic [RW-1:0]   a_row;
  logic [LW-1:0]   a_lines;
  seq_state_t      a_state;
  logic            b_sreq, b_drop, b_lock, b_shift, b_play, b_over;
  logic [RW-1:0]   b_row;
  logic [LW2-1:0]  b_lines;
  seq_state_t      b_state;

  game_sequencer #(.ROWS(ROWS), .GRAVITY_DIV(GDIV), .LINE_CNT_W(LW)) dut (
    .game_clk(game_clk), .reset(reset), .start(start),
    .spawn_ack(spawn_ack), .spawn_blocked(spawn_blocked),
    .piece_touching(piece_touching), .row_full(row_full),
`ifdef GAME_SEQ_SOFT_DROP_EN
    .soft_drop(soft_drop),
`endif
    .spawn_req(a_sreq), .drop_en(a_drop), .lock_en(a_lock), .shift_en(a_shift),
    .row_idx(a_row), .playing(a_play), .game_over(a_over),
    .lines_cleared(a_lines), .state_dbg(a_state)
  );

  game_sequencer #(.ROWS(ROWS), .GRAVITY_DIV(GDIV), .LINE_CNT_W(LW2)) dut_sat (
    .game_clk(game_clk), .reset(reset), .start(start),
    .spawn_ack(spawn_ack), .spawn_blocked(spawn_blocked),
    .piece_touching(piece_touching), .row_full(row_full),
`ifdef GAME_SEQ_SOFT_DROP_EN
    .soft_drop(soft_drop),
`endif
    .spawn_req(b_sreq), .drop_en(b_drop), .lock_en(b_lock), .shift_en(b_shift),
    .row_idx(b_row), .playing(b_play), .game_over(b_over),
    .lines_cleared(b_lines), .state_dbg(b_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    bit rst, st, ack, blk, tch, full, sd;
    seq_state_t s;
    bit sreq, drp, lck, shf;
    int row;
    bit ply, ovr;
    int lines;
  } vec_t;

  vec_t vq[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic add(input bit rst, st, ack, blk, tch, full, sd,
                     input seq_state_t s, input bit sreq, drp, lck, shf,
                     input int row, input bit ply, ovr, input int lines);
    vec_t v;
    v.rst = rst; v.st = st; v.ack = ack; v.blk = blk; v.tch = tch;
    v.full = full; v.sd = sd; v.s = s; v.sreq = sreq; v.drp = drp;
    v.lck = lck; v.shf = shf; v.row = row; v.ply = ply; v.ovr = ovr;
    v.lines = lines;
    vq.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    reset          = v.rst;
    start          = v.st;
    spawn_ack      = v.ack;
    spawn_blocked  = v.blk;
    piece_touching = v.tch;
    row_full       = v.full;
`ifdef GAME_SEQ_SOFT_DROP_EN
    soft_drop      = v.sd;
`endif
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input int i, input vec_t v);
    logic [W1-1:0] exp1, act1;
    logic [W2-1:0] exp2, act2;
    int l2;
    l2   = (v.lines > 3) ? 3 : v.lines;
    exp1 = {v.s, v.sreq, v.drp, v.lck, v.shf, RW'(v.row), v.ply, v.ovr, LW'(v.lines)};
    act1 = {a_state, a_sreq, a_drop, a_lock, a_shift, a_row, a_play, a_over, a_lines};
    exp2 = {v.s, v.sreq, v.drp, v.lck, v.shf, RW'(v.row), v.ply, v.ovr, LW2'(l2)};
    act2 = {b_state, b_sreq, b_drop, b_lock, b_shift, b_row, b_play, b_over, b_lines};
    n_checks++;
    if (act1 === exp1) n_pass++;
    else $display("FAIL vec%0d main: got %h expected %h (state,sreq,drop,lock,shift,row,play,over,lines)",
                  i, act1, exp1);
    n_checks++;
    if (act2 === exp2) n_pass++;
    else $display("FAIL vec%0d sat: got %h expected %h", i, act2, exp2);
  endtask

  initial begin
    vec_t z;
    z = '{default: 0, s: SEQ_IDLE};
    z.rst = 1'b1;
    drive(z);
    repeat (2) @(posedge game_clk);

    // Normal piece: slow spawn, three drops, touch mid-window, lock, clear rows 19/18.
    add(1,0,0,0,0,0,0, SEQ_IDLE, 0,0,0,0, 0, 0,0, 0);
    add(0,0,0,0,0,0,0, SEQ_IDLE, 0,0,0,0, 0, 0,0, 0);
    add(0,1,0,0,0,0,0, SEQ_IDLE, 0,0,0,0, 0, 0,0, 0);
    add(0,0,0,0,0,0,0, SEQ_SPAWN, 1,0,0,0, 0, 1,0, 0);
    add(0,0,0,0,0,0,0, SEQ_SPAWN, 1,0,0,0, 0, 1,0, 0);
    add(0,0,1,0,0,0,0, SEQ_SPAWN, 1,0,0,0, 0, 1,0, 0);
    for (int c = 1; c <= 24; c++)
      add(0,0,1,1,0,1,0, SEQ_FALL, 0,(c % 8 == 0),0,0, 0, 1,0, 0);
    for (int c = 25; c <= 32; c++)
      add(0,0,0,0,(c >= 29),0,0, SEQ_FALL, 0,0,0,0, 0, 1,0, 0);
    add(0,0,0,0,0,0,0, SEQ_LOCK,  0,0,1,0,  0, 1,0, 0);
    add(0,0,0,0,0,1,0, SEQ_SCAN,  0,0,0,0, 19, 1,0, 0);
    add(0,0,0,0,0,0,0, SEQ_SHIFT, 0,0,0,1, 19, 1,0, 0);
    add(0,0,0,0,0,0,0, SEQ_SCAN,  0,0,0,0, 19, 1,0, 1);
    add(0,0,0,0,0,1,0, SEQ_SCAN,  0,0,0,0, 18, 1,0, 1);
    add(0,0,0,0,0,0,0, SEQ_SHIFT, 0,0,0,1, 18, 1,0, 1);
    add(0,0,0,0,0,0,0, SEQ_SCAN,  0,0,0,0, 18, 1,0, 2);
    for (int r = 17; r >= 0; r--)
      add(0,0,1,1,1,0,0, SEQ_SCAN, 0,0,0,0, r, 1,0, 2);
    // Blocked spawn -> sticky game over; start ignored; reset returns to IDLE.
    add(0,0,1,1,0,0,0, SEQ_SPAWN, 1,0,0,0, 0, 1,0, 2);
    for (int k = 0; k < 4; k++)
      add(0,(k % 2 == 0),0,0,0,0,0, SEQ_OVER, 0,0,0,0, 0, 0,1, 2);
    add(1,1,0,0,0,0,0, SEQ_OVER, 0,0,0,0, 0, 0,0, 2);
    add(0,0,0,0,0,0,0, SEQ_IDLE, 0,0,0,0, 0, 0,0, 0);

    // Zero-wait spawn, touch exactly at the tick, reset during SHIFT.
    add(0,1,0,0,0,0,0, SEQ_IDLE,  0,0,0,0, 0, 0,0, 0);
    add(0,0,1,0,0,0,0, SEQ_SPAWN, 1,0,0,0, 0, 1,0, 0);
    for (int c = 1; c <= 8; c++)
      add(0,0,0,0,(c == 8),0,0, SEQ_FALL, 0,0,0,0, 0, 1,0, 0);
    add(0,0,0,0,0,0,0, SEQ_LOCK,  0,0,1,0,  0, 1,0, 0);
    add(0,0,0,0,0,1,0, SEQ_SCAN,  0,0,0,0, 19, 1,0, 0);
    add(0,0,0,0,0,0,0, SEQ_SHIFT, 0,0,0,1, 19, 1,0, 0);
    add(0,0,0,0,0,1,0, SEQ_SCAN,  0,0,0,0, 19, 1,0, 1);
    add(1,0,0,0,0,0,0, SEQ_SHIFT, 0,0,0,0, 19, 0,0, 1);
    add(0,0,0,0,0,0,0, SEQ_IDLE,  0,0,0,0,  0, 0,0, 0);

    // Five clears in a row: the 2-bit counter saturates at 3.
    add(0,1,0,0,0,0,0, SEQ_IDLE,  0,0,0,0, 0, 0,0, 0);
    add(0,0,1,0,0,0,0, SEQ_SPAWN, 1,0,0,0, 0, 1,0, 0);
    for (int c = 1; c <= 8; c++)
      add(0,0,0,0,1,0,0, SEQ_FALL, 0,0,0,0, 0, 1,0, 0);
    add(0,0,0,0,0,0,0, SEQ_LOCK, 0,0,1,0, 0, 1,0, 0);
    for (int k = 0; k < 5; k++) begin
      add(0,0,0,0,0,1,0, SEQ_SCAN,  0,0,0,0, 19, 1,0, k);
      add(0,0,0,0,0,0,0, SEQ_SHIFT, 0,0,0,1, 19, 1,0, k);
    end
    add(0,0,0,0,0,0,0, SEQ_SCAN, 0,0,0,0, 19, 1,0, 5);
    add(1,0,0,0,0,0,0, SEQ_SCAN, 0,0,0,0, 18, 0,0, 5);
    add(0,0,0,0,0,0,0, SEQ_IDLE, 0,0,0,0,  0, 0,0, 0);

`ifdef GAME_SEQ_SOFT_DROP_EN
    // Soft drop: a drop every cycle until touching, then lock.
    add(0,1,0,0,0,0,0, SEQ_IDLE,  0,0,0,0, 0, 0,0, 0);
    add(0,0,1,0,0,0,0, SEQ_SPAWN, 1,0,0,0, 0, 1,0, 0);
    for (int c = 1; c <= 3; c++)
      add(0,0,0,0,0,0,1, SEQ_FALL, 0,1,0,0, 0, 1,0, 0);
    add(0,0,0,0,1,0,1, SEQ_FALL, 0,0,0,0,  0, 1,0, 0);
    add(0,0,0,0,0,0,0, SEQ_LOCK, 0,0,1,0,  0, 1,0, 0);
    add(0,0,0,0,0,0,0, SEQ_SCAN, 0,0,0,0, 19, 1,0, 0);
    add(1,0,0,0,0,0,0, SEQ_SCAN, 0,0,0,0, 18, 0,0, 0);
    add(0,0,0,0,0,0,0, SEQ_IDLE, 0,0,0,0,  0, 0,0, 0);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge game_clk);
      drive(vq[i]);
      #1;
      check(i, vq[i]);
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
